// File: rtl/sa_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sa_skew_feeder
// Brief    : Input FIFO plus diagonal skew pipeline feeding SA_CORE array rows.
// Revision : 1.0 - initial release
// ============================================================================
module sa_skew_feeder #(
    parameter int ROWS       = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   in_last,
    input  logic                   in_mode,
    input  logic                   out_stall,
    output logic [ROWS*DATA_W-1:0] out_data,
    output logic [ROWS-1:0]        out_valid,
    output logic                   busy,
    output logic                   tile_done
);

    localparam int VW = ROWS * DATA_W;
    localparam int EW = VW + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ROWS);

    localparam logic [AW:0]   C_FULL       = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_FLUSH_INIT = CW'(ROWS - 1);
    localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // ------------------------------------------------------------------
    // Input FIFO: entry = {data, last, mode}
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_adv;
    logic [EW-1:0] w_head;
    logic [VW-1:0] w_head_data;
    logic          w_head_last;
    logic          w_head_mode;

    assign w_adv       = !out_stall;
    assign w_push      = in_valid && r_in_ready;
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[EW-1:2];
    assign w_head_last = w_head[1];
    assign w_head_mode = w_head[0];
    assign in_ready    = r_in_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_data, in_last, in_mode};
        end
    end

    // Ready is registered from the next occupancy, so a pop frees space one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != C_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Tile FSM and injection register
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_mode;
    logic          w_mode_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [VW-1:0] r_inj_data;
    logic          r_inj_valid;
    logic          r_inj_mode;
    logic [VW-1:0] w_inj_data;
    logic          w_inj_valid;
    logic          w_inj_mode;
    logic          w_pipe_busy;
    logic          w_tile_done;
    logic [ROWS-1:0] w_lane_busy;

    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;
        w_inj_valid  = 1'b0;
        w_inj_data   = '0;
        w_inj_mode   = r_mode;
        w_tile_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_adv && !w_empty) begin
                    w_pop       = 1'b1;
                    w_mode_next = w_head_mode;
                    w_inj_mode  = w_head_mode;
                    w_inj_valid = 1'b1;
                    w_inj_data  = w_head_data;
                    if (!w_head_last) begin
                        w_state_next = S_STREAM;
                    end else if (w_head_mode) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_FLUSH;
                        w_cnt_next   = C_FLUSH_INIT;
                    end
                end
            end
            S_STREAM: begin
                if (w_adv && !w_empty) begin
                    w_pop       = 1'b1;
                    w_inj_valid = 1'b1;
                    w_inj_data  = w_head_data;
                    if (w_head_last) begin
                        if (r_mode) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_FLUSH;
                            w_cnt_next   = C_FLUSH_INIT;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (w_adv) begin
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt == C_CNT_ONE) w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Pulse only once the last valid beat has drained from every lane.
                if (!w_pipe_busy) begin
                    w_tile_done = 1'b1;
                    if (w_adv) w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_inj_data  <= '0;
            r_inj_valid <= 1'b0;
            r_inj_mode  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mode  <= w_mode_next;
            r_cnt   <= w_cnt_next;
            if (w_adv) begin
                r_inj_data  <= w_inj_data;
                r_inj_valid <= w_inj_valid;
                r_inj_mode  <= w_inj_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skew chains: lane r holds r+1 stages; weight mode loads the tail directly
    // ------------------------------------------------------------------
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_lane
        logic [DATA_W-1:0] r_d [gr+1];
        logic [gr:0]       r_v;
        logic [DATA_W-1:0] w_in_d;

        assign w_in_d = r_inj_data[gr*DATA_W +: DATA_W];

        if (gr == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_d[0] <= '0;
                    r_v[0] <= 1'b0;
                end else if (w_adv) begin
                    r_d[0] <= w_in_d;
                    r_v[0] <= r_inj_valid;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j <= gr; j++) r_d[j] <= '0;
                    r_v <= '0;
                end else if (w_adv) begin
                    for (int j = 1; j <= gr; j++) r_d[j] <= r_d[j-1];
                    r_v[gr:1] <= r_v[gr-1:0];
                    if (r_inj_mode) begin
                        r_d[0]  <= '0;
                        r_v[0]  <= 1'b0;
                        r_d[gr] <= w_in_d;
                        r_v[gr] <= r_inj_valid;
                    end else begin
                        r_d[0] <= w_in_d;
                        r_v[0] <= r_inj_valid;
                    end
                end
            end
        end

        assign out_data[gr*DATA_W +: DATA_W] = r_d[gr];
        assign out_valid[gr]                 = r_v[gr];
        assign w_lane_busy[gr]               = |r_v;
    end

    assign w_pipe_busy = r_inj_valid || (|w_lane_busy);
    assign tile_done   = w_tile_done;
    assign busy        = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sa_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_skew_feeder
// Brief    : Directed self-checking bench for sa_skew_feeder (ROWS=8, DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_skew_feeder;

    localparam int LOGN = 1024;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        in_mode;
    logic        out_stall;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic        busy;
    logic        tile_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tk [4];

    logic [7:0]  log_v    [LOGN];
    logic [63:0] log_d    [LOGN];
    logic        log_done [LOGN];
    logic        log_rdy  [LOGN];

    sa_skew_feeder #(.ROWS(8), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_mode   (in_mode),
        .out_stall (out_stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .tile_done (tile_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry cyc holds the outputs as they stand just after edge number cyc.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (cyc < LOGN) begin
            log_v[cyc]    = out_valid;
            log_d[cyc]    = out_data;
            log_done[cyc] = tile_done;
            log_rdy[cyc]  = in_ready;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] beat(input int base, input int k);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) v[r*8 +: 8] = 8'(base + 16*k + r);
        return v;
    endfunction

    task automatic push(input logic [63:0] d, input logic last, input logic mode, output int n);
        bit ok;
        int guard;
        in_valid = 1'b1; in_data = d; in_last = last; in_mode = mode;
        ok = 1'b0; guard = 0;
        while (!ok && guard < 64) begin
            ok = in_ready;
            @(posedge clk); #2;
            guard++;
        end
        if (!ok) check("push_to", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0;
        n = cyc;
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 400) begin
            @(posedge clk); #2;
            guard++;
        end
        if (cyc < target) check("wait_to", 64'(cyc), 64'(target));
    endtask

    // Lane r of beat k is expected right after edge tk[k]+2+r (tk[k]+2 in weight mode).
    task automatic check_tile(input string tag, input int nb, input int base, input bit mode,
                              input int lo, input int hi);
        logic [7:0]  ev;
        logic [63:0] ed;
        for (int c = lo; c <= hi; c++) begin
            ev = '0; ed = '0;
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < nb; k++)
                    if (c == tk[k] + 2 + (mode ? 0 : r)) begin
                        ev[r] = 1'b1;
                        ed[r*8 +: 8] = 8'(base + 16*k + r);
                    end
            check($sformatf("%s_v@%0d", tag, c - lo), {56'd0, log_v[c]}, {56'd0, ev});
            check($sformatf("%s_d@%0d", tag, c - lo), log_d[c], ed);
        end
    endtask

    task automatic check_done(input string tag, input int lo, input int hi,
                              input int exp_n, input int exp_first);
        int n;
        int first;
        n = 0; first = -1;
        for (int c = lo; c <= hi; c++)
            if (log_done[c]) begin
                n++;
                if (first < 0) first = c;
            end
        check({tag, "_done_cnt"}, 64'(n), 64'(exp_n));
        check({tag, "_done_at"}, 64'(first - lo), 64'(exp_first - lo));
        if (first >= 0) check({tag, "_done_vz"}, {56'd0, log_v[first]}, 64'd0);
    endtask

    initial begin
        int s;
        int r0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_mode = 1'b0;
        out_stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", {56'd0, out_valid}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, tile_done}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #2;
        check("rst_ready", {63'd0, in_ready}, 64'd1);

        // Activation tile, 4 back-to-back beats
        for (int k = 0; k < 4; k++) push(beat(0, k), k == 3, 1'b0, tk[k]);
        wait_cyc(tk[3] + 13);
        check_tile("m0", 4, 0, 1'b0, tk[0], tk[3] + 11);
        check_done("m0", tk[0], tk[3] + 12, 1, tk[3] + 10);

        // Weight tile, same beats
        for (int k = 0; k < 4; k++) push(beat(0, k), k == 3, 1'b1, tk[k]);
        wait_cyc(tk[3] + 6);
        check_tile("m1", 4, 0, 1'b1, tk[0], tk[3] + 5);
        check_done("m1", tk[0], tk[3] + 5, 1, tk[3] + 3);

        // Fill the FIFO under stall, then release
        out_stall = 1'b1;
        for (int k = 0; k < 4; k++) push(beat(128, k), k == 3, 1'b0, tk[k]);
        check("full_rdy", {63'd0, in_ready}, 64'd0);
        check("stall_busy", {63'd0, busy}, 64'd1);
        repeat (3) begin
            @(posedge clk); #2;
            check("frz_valid", {56'd0, out_valid}, 64'd0);
            check("frz_rdy", {63'd0, in_ready}, 64'd0);
        end
        s = cyc;
        out_stall = 1'b0;
        for (int k = 0; k < 4; k++) tk[k] = s + k;
        wait_cyc(s + 16);
        check("rdy_hold", {63'd0, log_rdy[s]}, 64'd0);
        check("rdy_back", {63'd0, log_rdy[s+1]}, 64'd1);
        check_tile("stall", 4, 128, 1'b0, s, s + 14);
        check_done("stall", s, s + 15, 1, s + 13);

        // Upstream gap of 3 cycles between beats 1 and 2
        push(beat(64, 0), 1'b0, 1'b0, tk[0]);
        push(beat(64, 1), 1'b0, 1'b0, tk[1]);
        repeat (3) begin @(posedge clk); #2; end
        push(beat(64, 2), 1'b1, 1'b0, tk[2]);
        wait_cyc(tk[2] + 13);
        check_tile("gap", 3, 64, 1'b0, tk[0], tk[2] + 11);
        check_done("gap", tk[0], tk[2] + 12, 1, tk[2] + 10);

        // Reset while lane 5 holds a valid beat during flush
        push(beat(16, 0), 1'b1, 1'b0, tk[0]);
        wait_cyc(tk[0] + 7);
        check("pre_v5", {63'd0, out_valid[5]}, 64'd1);
        check("pre_d5", {56'd0, out_data[47:40]}, 64'd21);
        rst = 1'b1;
        @(posedge clk); #2;
        r0 = cyc;
        check("mid_rst_valid", {56'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, tile_done}, 64'd0);
        rst = 1'b0;
        push(beat(32, 0), 1'b0, 1'b0, tk[0]);
        push(beat(32, 1), 1'b1, 1'b0, tk[1]);
        wait_cyc(tk[1] + 13);
        check_tile("post", 2, 32, 1'b0, r0, tk[1] + 11);
        check_done("post", r0, tk[1] + 12, 1, tk[1] + 10);

        // Activation tile followed by weight tile, both queued
        out_stall = 1'b1;
        push(beat(80, 0), 1'b0, 1'b0, tk[0]);
        push(beat(80, 1), 1'b1, 1'b0, tk[1]);
        push(beat(96, 0), 1'b0, 1'b1, tk[2]);
        push(beat(96, 1), 1'b1, 1'b1, tk[3]);
        s = cyc;
        out_stall = 1'b0;
        wait_cyc(s + 20);
        tk[0] = s; tk[1] = s + 1;
        check_tile("b2bA", 2, 80, 1'b0, s, s + 11);
        tk[0] = s + 12; tk[1] = s + 13;
        check_tile("b2bB", 2, 96, 1'b1, s + 12, s + 17);
        check_done("b2b", s, s + 19, 2, s + 11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
